// File: rtl/counter_pkg.sv
// ---------------------------------------------------------------------------
// counter_pkg
// Shared types and default widths for the up/down modulus counter
// (counter_updn_mod and its combinational next-state block).
//
// Contents:
//   CNT_WIDTH_DEF / CNT_STEP_W_DEF - default counter and step widths
//   CNT_WRAP_W_DEF                 - default wrap-event counter width
//                                    (only with CNT_WRAP_COUNT_EN)
//   cnt_mode_e                     - wrap / saturate mode, matched against the sat port
//   cnt_status_t                   - registered boundary pulse and range flags
// ---------------------------------------------------------------------------
package counter_pkg;

    localparam int CNT_WIDTH_DEF  = 8;
    localparam int CNT_STEP_W_DEF = 4;
`ifdef CNT_WRAP_COUNT_EN
    localparam int CNT_WRAP_W_DEF = 8;
`endif

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } cnt_mode_e;

    typedef struct packed {
        logic tc;       // one-cycle boundary pulse
        logic at_max;   // cnt == limit
        logic at_zero;  // cnt == 0
    } cnt_status_t;

endpackage : counter_pkg

// File: rtl/counter_updn_mod_next.sv
// ---------------------------------------------------------------------------
// counter_updn_mod_next
// Purely combinational next-count calculation for one enabled counting cycle:
// step clamping, wrap/saturate handling and recovery from an out-of-range
// count. Load, enable and reset priority live in the parent.
//
// Ports:
//   cnt_i      [WIDTH-1:0]  current count
//   step_i     [STEP_W-1:0] requested step magnitude (0 = hold)
//   limit_i    [WIDTH-1:0]  upper bound, legal range 0..limit
//   down_i                  0 = count up, 1 = count down
//   sat_i                   0 = wrap, 1 = saturate (see cnt_mode_e)
//   cnt_nxt_o  [WIDTH-1:0]  count after this step
//   tc_o                    boundary event on this step
// ---------------------------------------------------------------------------
module counter_updn_mod_next
    import counter_pkg::*;
#(
    parameter int WIDTH  = CNT_WIDTH_DEF,
    parameter int STEP_W = CNT_STEP_W_DEF
) (
    input  logic [WIDTH-1:0]  cnt_i,
    input  logic [STEP_W-1:0] step_i,
    input  logic [WIDTH-1:0]  limit_i,
    input  logic              down_i,
    input  logic              sat_i,
    output logic [WIDTH-1:0]  cnt_nxt_o,
    output logic              tc_o
);

    // One extra bit so limit+1 (the modulus) is representable even when
    // limit is all ones; the step compare is widened if the step port is wider.
    localparam int MW = (STEP_W > WIDTH + 1) ? STEP_W : WIDTH + 1;

    typedef logic [WIDTH:0] ext_t;

    typedef struct packed {
        logic [WIDTH-1:0] value;
        logic             tc;
    } next_t;

    ext_t      cnt_e;
    ext_t      lim_e;
    ext_t      modulus;
    ext_t      s_eff;
    ext_t      sum;
    cnt_mode_e mode;
    next_t     res;

    // NOTE: every variable written here gets a default before any branch, so
    // no path leaves a value unassigned and no latch can be inferred.
    always_comb begin
        cnt_e     = {1'b0, cnt_i};
        lim_e     = {1'b0, limit_i};
        modulus   = lim_e + ext_t'(1);
        // A step larger than the modulus is clamped to the modulus.
        s_eff     = (MW'(step_i) > MW'(modulus)) ? modulus : ext_t'(step_i);
        mode      = cnt_mode_e'(sat_i);
        sum       = cnt_e + s_eff;
        res.value = cnt_i;
        res.tc    = 1'b0;

        if (s_eff == '0) begin
            // zero step: hold
        end else if (cnt_e > lim_e) begin
            // Out of range after a load or a lowered limit: snap back into range.
            res.tc = 1'b1;
            if (down_i || mode == CNT_SAT) begin
                res.value = limit_i;
            end else begin
                res.value = '0;
            end
        end else if (!down_i) begin
            if (sum <= lim_e) begin
                res.value = sum[WIDTH-1:0];
            end else if (mode == CNT_WRAP) begin
                res.value = WIDTH'(sum - modulus);
                res.tc    = 1'b1;
            end else if (cnt_i != limit_i) begin
                // Saturation only pulses when the count actually moves to the bound.
                res.value = limit_i;
                res.tc    = 1'b1;
            end
        end else begin
            if (cnt_e >= s_eff) begin
                res.value = WIDTH'(cnt_e - s_eff);
            end else if (mode == CNT_WRAP) begin
                res.value = WIDTH'(cnt_e + modulus - s_eff);
                res.tc    = 1'b1;
            end else if (cnt_i != '0) begin
                res.value = '0;
                res.tc    = 1'b1;
            end
        end
    end

    assign cnt_nxt_o = res.value;
    assign tc_o      = res.tc;

endmodule : counter_updn_mod_next

// File: rtl/counter_updn_mod.sv
// ---------------------------------------------------------------------------
// counter_updn_mod
// Up/down counter with run-time modulus (limit+1), programmable step,
// synchronous load and wrap or saturate mode. Produces a registered
// one-cycle terminal-count pulse and registered range flags. All logic runs
// on the rising edge of clk50m; rst is synchronous and active high.
// Priority: rst > load > en.
//
// Optional build macro: CNT_WRAP_COUNT_EN adds the WRAP_W parameter and the
// wraps output, a saturating count of tc pulses cleared by rst and load.
//
// Ports:
//   clk50m                 system clock
//   rst                    synchronous active-high reset
//   en                     count enable, one step per enabled cycle
//   down                   0 = up, 1 = down
//   load                   synchronous load strobe
//   load_val [WIDTH-1:0]   value loaded on load (stored as-is, even above limit)
//   step     [STEP_W-1:0]  step magnitude, 0 = hold
//   limit    [WIDTH-1:0]   upper bound of the count range
//   sat                    0 = wrap, 1 = saturate
//   cnt      [WIDTH-1:0]   current count
//   tc                     registered boundary pulse
//   at_max                 registered cnt == limit
//   at_zero                registered cnt == 0
//   wraps    [WRAP_W-1:0]  tc event count (CNT_WRAP_COUNT_EN only)
// ---------------------------------------------------------------------------
module counter_updn_mod
    import counter_pkg::*;
#(
    parameter int WIDTH  = CNT_WIDTH_DEF,
    parameter int STEP_W = CNT_STEP_W_DEF
`ifdef CNT_WRAP_COUNT_EN
   ,parameter int WRAP_W = CNT_WRAP_W_DEF
`endif
) (
    input  logic              clk50m,
    input  logic              rst,
    input  logic              en,
    input  logic              down,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  limit,
    input  logic              sat,
    output logic [WIDTH-1:0]  cnt,
    output logic              tc,
    output logic              at_max,
    output logic              at_zero
`ifdef CNT_WRAP_COUNT_EN
   ,output logic [WRAP_W-1:0] wraps
`endif
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] step_cnt;
    logic             step_tc;
    cnt_status_t      status_q;
    cnt_status_t      status_d;

    counter_updn_mod_next #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W)
    ) u_next (
        .cnt_i     (cnt_q),
        .step_i    (step),
        .limit_i   (limit),
        .down_i    (down),
        .sat_i     (sat),
        .cnt_nxt_o (step_cnt),
        .tc_o      (step_tc)
    );

    // Load beats enable; the flags are derived from the next count and the
    // limit presented this cycle so they line up with cnt.
    always_comb begin
        cnt_d       = cnt_q;
        status_d.tc = 1'b0;
        if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            cnt_d       = step_cnt;
            status_d.tc = step_tc;
        end
        status_d.at_max  = (cnt_d == limit);
        status_d.at_zero = (cnt_d == '0);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk50m) begin
        if (rst) begin
            cnt_q            <= '0;
            status_q.tc      <= 1'b0;
            status_q.at_max  <= (limit == '0);
            status_q.at_zero <= 1'b1;
        end else begin
            cnt_q    <= cnt_d;
            status_q <= status_d;
        end
    end

`ifdef CNT_WRAP_COUNT_EN
    logic [WRAP_W-1:0] wraps_q;

    always_ff @(posedge clk50m) begin
        if (rst || load) begin
            wraps_q <= '0;
        end else if (status_d.tc && (wraps_q != '1)) begin
            wraps_q <= wraps_q + WRAP_W'(1);
        end
    end

    assign wraps = wraps_q;
`endif

    assign cnt     = cnt_q;
    assign tc      = status_q.tc;
    assign at_max  = status_q.at_max;
    assign at_zero = status_q.at_zero;

endmodule : counter_updn_mod

// File: tb/tb_counter_updn_mod.sv
// ---------------------------------------------------------------------------
// tb_counter_updn_mod
// Directed table of {inputs, expected outputs} applied one clock at a time,
// followed by hand-written multi-cycle sequences (full-range lap and, when
// CNT_WRAP_COUNT_EN is defined, the saturating wrap counter).
// ---------------------------------------------------------------------------
`timescale 1ns / 1ps

module tb_counter_updn_mod;

    localparam int WIDTH  = 8;
    localparam int STEP_W = 4;

    typedef struct {
        logic             rst;
        logic             load;
        logic [WIDTH-1:0] load_val;
        logic             en;
        logic             down;
        logic [STEP_W-1:0] step;
        logic [WIDTH-1:0] limit;
        logic             sat;
        logic [WIDTH-1:0] exp_cnt;
        logic             exp_tc;
        logic             exp_max;
        logic             exp_zero;
    } vec_t;

    logic              clk50m;
    logic              rst;
    logic              en;
    logic              down;
    logic              load;
    logic [WIDTH-1:0]  load_val;
    logic [STEP_W-1:0] step;
    logic [WIDTH-1:0]  limit;
    logic              sat;
    logic [WIDTH-1:0]  cnt;
    logic              tc;
    logic              at_max;
    logic              at_zero;
`ifdef CNT_WRAP_COUNT_EN
    logic [7:0]        wraps;
`endif

    int n_total = 0;
    int n_pass  = 0;
    vec_t vecs[$];

    counter_updn_mod #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W)
    ) dut (
        .clk50m   (clk50m),
        .rst      (rst),
        .en       (en),
        .down     (down),
        .load     (load),
        .load_val (load_val),
        .step     (step),
        .limit    (limit),
        .sat      (sat),
        .cnt      (cnt),
        .tc       (tc),
        .at_max   (at_max),
        .at_zero  (at_zero)
`ifdef CNT_WRAP_COUNT_EN
       ,.wraps    (wraps)
`endif
    );

    initial begin
        clk50m = 1'b0;
        forever #10 clk50m = ~clk50m;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void add(
        input logic r, input logic ld, input logic [7:0] lv, input logic e,
        input logic dn, input logic [3:0] st, input logic [7:0] lim, input logic sm,
        input logic [7:0] ec, input logic et, input logic emx, input logic ez);
        vec_t v;
        v.rst = r;  v.load = ld; v.load_val = lv; v.en = e;
        v.down = dn; v.step = st; v.limit = lim; v.sat = sm;
        v.exp_cnt = ec; v.exp_tc = et; v.exp_max = emx; v.exp_zero = ez;
        vecs.push_back(v);
    endfunction

    // Drive on the falling edge, sample 1 ns after the following rising edge.
    task automatic drive(input logic r, input logic ld, input logic [7:0] lv, input logic e,
                         input logic dn, input logic [3:0] st, input logic [7:0] lim,
                         input logic sm);
        @(negedge clk50m);
        rst = r; load = ld; load_val = lv; en = e;
        down = dn; step = st; limit = lim; sat = sm;
        @(posedge clk50m);
        #1;
    endtask

    initial begin
        int tc_seen;

        rst = 1'b1; load = 1'b0; load_val = '0; en = 1'b0;
        down = 1'b0; step = '0; limit = '0; sat = 1'b0;

        //    rst ld  lv     en dn st  lim    sat   cnt    tc max zero
        // reset overrides load, then load
        add(1, 1, 8'h55, 0, 0, 0,  8'd9,  0,   8'h00, 0, 0, 1);
        add(0, 1, 8'h55, 0, 0, 0,  8'd9,  0,   8'h55, 0, 0, 0);
        add(0, 1, 8'h00, 0, 0, 0,  8'd9,  0,   8'h00, 0, 0, 1);
        // wrap up, limit 9, step 3
        add(0, 0, 8'h00, 1, 0, 3,  8'd9,  0,   8'd3,  0, 0, 0);
        add(0, 0, 8'h00, 1, 0, 3,  8'd9,  0,   8'd6,  0, 0, 0);
        add(0, 0, 8'h00, 1, 0, 3,  8'd9,  0,   8'd9,  0, 1, 0);
        add(0, 0, 8'h00, 1, 0, 3,  8'd9,  0,   8'd2,  1, 0, 0);
        add(0, 0, 8'h00, 1, 0, 3,  8'd9,  0,   8'd5,  0, 0, 0);
        // wrap down, limit 9, step 4, from 2
        add(0, 1, 8'h02, 0, 0, 0,  8'd9,  0,   8'd2,  0, 0, 0);
        add(0, 0, 8'h00, 1, 1, 4,  8'd9,  0,   8'd8,  1, 0, 0);
        add(0, 0, 8'h00, 1, 1, 4,  8'd9,  0,   8'd4,  0, 0, 0);
        add(0, 0, 8'h00, 1, 1, 4,  8'd9,  0,   8'd0,  0, 0, 1);
        add(0, 0, 8'h00, 1, 1, 4,  8'd9,  0,   8'd6,  1, 0, 0);
        // hold: en=0, then step=0
        add(0, 0, 8'h00, 0, 1, 4,  8'd9,  0,   8'd6,  0, 0, 0);
        add(0, 0, 8'h00, 1, 1, 0,  8'd9,  0,   8'd6,  0, 0, 0);
        // saturate, limit 200, step 15
        add(0, 1, 8'd190, 0, 0, 15, 8'd200, 1,  8'd190, 0, 0, 0);
        add(0, 0, 8'h00, 1, 0, 15, 8'd200, 1,  8'd200, 1, 1, 0);
        add(0, 0, 8'h00, 1, 0, 15, 8'd200, 1,  8'd200, 0, 1, 0);
        add(0, 1, 8'd10, 0, 0, 15, 8'd200, 1,  8'd10,  0, 0, 0);
        add(0, 0, 8'h00, 1, 1, 15, 8'd200, 1,  8'd0,   1, 0, 1);
        add(0, 0, 8'h00, 1, 1, 15, 8'd200, 1,  8'd0,   0, 0, 1);
        // out of range after load, limit 0x20
        add(0, 1, 8'hF0, 0, 0, 1,  8'h20, 0,   8'hF0, 0, 0, 0);
        add(0, 0, 8'h00, 1, 0, 1,  8'h20, 0,   8'h00, 1, 0, 1);
        add(0, 1, 8'hF0, 0, 0, 1,  8'h20, 0,   8'hF0, 0, 0, 0);
        add(0, 0, 8'h00, 1, 1, 1,  8'h20, 0,   8'h20, 1, 1, 0);
        add(0, 1, 8'hF0, 0, 0, 1,  8'h20, 1,   8'hF0, 0, 0, 0);
        add(0, 0, 8'h00, 1, 0, 1,  8'h20, 1,   8'h20, 1, 1, 0);
        // step clamp: limit 2, step 15 -> effective 3
        add(0, 1, 8'h01, 0, 0, 15, 8'd2,  0,   8'h01, 0, 0, 0);
        add(0, 0, 8'h00, 1, 0, 15, 8'd2,  0,   8'h01, 1, 0, 0);
        // limit 0 in wrap mode
        add(0, 1, 8'h00, 0, 0, 5,  8'd0,  0,   8'h00, 0, 1, 1);
        add(0, 0, 8'h00, 1, 0, 5,  8'd0,  0,   8'h00, 1, 1, 1);
        // full range modulus 256
        add(0, 1, 8'hFF, 0, 0, 1,  8'hFF, 0,   8'hFF, 0, 1, 0);
        add(0, 0, 8'h00, 1, 0, 1,  8'hFF, 0,   8'h00, 1, 0, 1);
        add(0, 0, 8'h00, 1, 1, 1,  8'hFF, 0,   8'hFF, 1, 1, 0);
        // load beats enable, reset beats enable, reset flag with limit 0
        add(0, 1, 8'h10, 1, 0, 1,  8'hFF, 0,   8'h10, 0, 0, 0);
        add(1, 0, 8'h00, 1, 0, 1,  8'hFF, 0,   8'h00, 0, 0, 1);
        add(1, 0, 8'h00, 0, 0, 0,  8'd0,  0,   8'h00, 0, 1, 1);
        // lowered limit without load, then recovery in saturate-down
        add(0, 1, 8'h30, 0, 0, 1,  8'hFF, 0,   8'h30, 0, 0, 0);
        add(0, 0, 8'h00, 0, 0, 1,  8'h10, 0,   8'h30, 0, 0, 0);
        add(0, 0, 8'h00, 1, 1, 1,  8'h10, 1,   8'h10, 1, 1, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].load, vecs[i].load_val, vecs[i].en,
                  vecs[i].down, vecs[i].step, vecs[i].limit, vecs[i].sat);
            check($sformatf("v%0d_cnt", i),     32'(cnt),     32'(vecs[i].exp_cnt));
            check($sformatf("v%0d_tc", i),      32'(tc),      32'(vecs[i].exp_tc));
            check($sformatf("v%0d_at_max", i),  32'(at_max),  32'(vecs[i].exp_max));
            check($sformatf("v%0d_at_zero", i), 32'(at_zero), 32'(vecs[i].exp_zero));
        end

        // Full lap of 256 unit steps from 0: exactly one tc, back at 0.
        drive(0, 1, 8'h00, 0, 0, 1, 8'hFF, 0);
        tc_seen = 0;
        for (int k = 0; k < 256; k++) begin
            drive(0, 0, 8'h00, 1, 0, 1, 8'hFF, 0);
            if (tc) tc_seen++;
        end
        check("lap_tc_count", 32'(tc_seen), 32'd1);
        check("lap_cnt",      32'(cnt),     32'd0);

`ifdef CNT_WRAP_COUNT_EN
        // limit 0, wrap mode: every enabled cycle is a tc event.
        drive(1, 0, 8'h00, 0, 0, 1, 8'd0, 0);
        check("wraps_reset", 32'(wraps), 32'd0);
        for (int k = 0; k < 10; k++) drive(0, 0, 8'h00, 1, 0, 1, 8'd0, 0);
        check("wraps_10", 32'(wraps), 32'd10);
        for (int k = 0; k < 290; k++) drive(0, 0, 8'h00, 1, 0, 1, 8'd0, 0);
        check("wraps_sat", 32'(wraps), 32'hFF);
        drive(0, 1, 8'h00, 1, 0, 1, 8'd0, 0);
        check("wraps_load", 32'(wraps), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_counter_updn_mod
